// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester and transmitter handshake bundle for uart_tx_arbiter
// Signals:
//   req, req_data      requester level requests and their packed bytes (byte i at [i*DATA_W +: DATA_W])
//   gnt, done          one-hot pulses back to the requesters
//   tx_start, tx_data  start pulse and latched byte towards the UART transmitter
//   tx_busy, tx_done   transmitter status back to the arbiter
// Modports: master = arbiter side, slave = clients/transmitter side.
interface uart_tx_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8
);
    logic [N_REQ-1:0]        req;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        gnt;
    logic [N_REQ-1:0]        done;
    logic                    tx_start;
    logic [DATA_W-1:0]       tx_data;
    logic                    tx_busy;
    logic                    tx_done;

    modport master (
        input  req, req_data, tx_busy, tx_done,
        output gnt, done, tx_start, tx_data
    );

    modport slave (
        output req, req_data, tx_busy, tx_done,
        input  gnt, done, tx_start, tx_data
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sequencer sharing one UART transmitter among N_REQ byte sources
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-low
//   bus          uart_tx_arbiter_if.master (req/req_data/gnt/done, tx_start/tx_data/tx_busy/tx_done)
//   busy         1 whenever the sequencer is not IDLE
//   owner        index of the current/last granted requester
//   timeout_err  1-cycle pulse when the WAIT watchdog aborts a frame
// Optional feature: define UART_ARB_TIMEOUT_EN to enable the WAIT watchdog (TIMEOUT_CYC cycles);
// without it WAIT holds until tx_done and timeout_err stays 0.
module uart_tx_arbiter #(
    parameter int N_REQ       = 4,
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                     clk,
    input  logic                     reset,
    uart_tx_arbiter_if.master        bus,
    output logic                     busy,
    output logic [$clog2(N_REQ)-1:0] owner,
    output logic                     timeout_err
);
    localparam int IW = $clog2(N_REQ);

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT} state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     ptr_q, ptr_d, owner_q, owner_d, sel;
    logic [DATA_W-1:0] data_q, data_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d, done_q, done_d;
    logic              start_q, start_d, terr_q, terr_d, hit, tmo;

    // Scan downward so the last hit kept is the nearest requester after ptr.
    always_comb begin
        sel = ptr_q;
        hit = 1'b0;
        for (int k = N_REQ; k >= 1; k--) begin
            if (bus.req[(int'(ptr_q) + k) % N_REQ]) begin
                sel = IW'((int'(ptr_q) + k) % N_REQ);
                hit = 1'b1;
            end
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC);
    logic [CW-1:0] cnt_q, cnt_d;

    // tx_done on the limit cycle takes priority over the abort.
    always_comb begin
        tmo   = state_q == S_WAIT && !bus.tx_done && cnt_q == CW'(TIMEOUT_CYC - 1);
        cnt_d = state_q == S_WAIT ? cnt_q + 1'b1 : '0;
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYC;
    assign tmo = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        data_d  = data_q;
        gnt_d   = '0;
        done_d  = '0;
        start_d = 1'b0;
        terr_d  = tmo;
        if (state_q == S_IDLE && hit && !bus.tx_busy) begin
            state_d = S_START;
            ptr_d   = sel;
            owner_d = sel;
            data_d  = bus.req_data[int'(sel)*DATA_W +: DATA_W];
            gnt_d   = N_REQ'(1) << sel;
        end
        if (state_q == S_START) begin
            state_d = S_WAIT;
            start_d = 1'b1;
        end
        if (state_q == S_WAIT && (bus.tx_done || tmo)) begin
            state_d = S_IDLE;
            done_d  = bus.tx_done ? N_REQ'(1) << owner_q : '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            ptr_q   <= IW'(N_REQ - 1);
            owner_q <= '0;
            data_q  <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            start_q <= 1'b0;
            terr_q  <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            data_q  <= data_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            start_q <= start_d;
            terr_q  <= terr_d;
`ifdef UART_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.done     = done_q;
    assign bus.tx_start = start_q;
    assign bus.tx_data  = data_q;
    assign busy         = state_q != S_IDLE;
    assign owner        = owner_q;
    assign timeout_err  = terr_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;
    localparam int N = 4;
    localparam int W = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       busy;
    logic [1:0] owner;
    logic       timeout_err;
    int         checks = 0;
    int         failures = 0;

    uart_tx_arbiter_if #(.N_REQ(N), .DATA_W(W)) bus();

    uart_tx_arbiter #(.N_REQ(N), .DATA_W(W), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .reset(reset), .bus(bus), .busy(busy), .owner(owner), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_gnt();
        int n = 0;
        while (bus.gnt == '0 && n < 30) begin
            step();
            n++;
        end
    endtask

    task automatic wait_start();
        int n = 0;
        while (!bus.tx_start && n < 30) begin
            step();
            n++;
        end
    endtask

    task automatic pulse_done();
        bus.tx_busy = 1'b0;
        bus.tx_done = 1'b1;
        step();
        bus.tx_done = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.req = '0;
        bus.req_data = 32'h44332211;
        bus.tx_busy = 1'b0;
        bus.tx_done = 1'b0;
        step();
        step();
        checks++;
        if ({bus.gnt, bus.done, bus.tx_start, bus.tx_data, busy, owner, timeout_err} !== '0) begin
            failures++;
            $display("FAIL rst_idle got gnt=%b done=%b start=%b data=%h busy=%b owner=%0d terr=%b exp all 0",
                     bus.gnt, bus.done, bus.tx_start, bus.tx_data, busy, owner, timeout_err);
        end
        reset = 1'b1;
        bus.req = 4'b1111;
        step();
        checks++;
        if (bus.gnt !== 4'b0001) begin
            failures++;
            $display("FAIL rst_first_gnt got=%b exp=0001", bus.gnt);
        end
        step();
        checks++;
        if (bus.tx_start !== 1'b1 || bus.tx_data !== 8'h11) begin
            failures++;
            $display("FAIL start_latency got start=%b data=%h exp start=1 data=11", bus.tx_start, bus.tx_data);
        end
        step();
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({bus.gnt, bus.done, bus.tx_start, bus.tx_data, busy, owner, timeout_err} !== '0) begin
            failures++;
            $display("FAIL rst_async got gnt=%b done=%b start=%b data=%h busy=%b owner=%0d terr=%b exp all 0",
                     bus.gnt, bus.done, bus.tx_start, bus.tx_data, busy, owner, timeout_err);
        end
        step();
        reset = 1'b1;
        step();
        checks++;
        if (bus.gnt !== 4'b0001 || owner !== 2'd0) begin
            failures++;
            $display("FAIL rst_regrant got gnt=%b owner=%0d exp gnt=0001 owner=0", bus.gnt, owner);
        end
        bus.req = '0;
        wait_start();
        pulse_done();
        checks++;
        if (bus.done !== 4'b0001) begin
            failures++;
            $display("FAIL rst_done got=%b exp=0001", bus.done);
        end
        step();
    endtask

    task automatic test_round_robin();
        reset = 1'b0;
        bus.req = 4'b1111;
        step();
        reset = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wait_gnt();
            checks++;
            if (bus.gnt !== 4'(1 << (k % 4)) || owner !== 2'(k % 4)) begin
                failures++;
                $display("FAIL rr_gnt%0d got gnt=%b owner=%0d exp gnt=%b owner=%0d",
                         k, bus.gnt, owner, 4'(1 << (k % 4)), k % 4);
            end
            wait_start();
            bus.tx_busy = 1'b1;
            repeat (9) step();
            if (k == 4) bus.req = '0;
            pulse_done();
            checks++;
            if (bus.done !== 4'(1 << (k % 4))) begin
                failures++;
                $display("FAIL rr_done%0d got=%b exp=%b", k, bus.done, 4'(1 << (k % 4)));
            end
        end
        step();
    endtask

    task automatic test_data();
        bus.req_data = {8'h11, 8'hA5, 8'h22, 8'h33};
        bus.req = 4'b0100;
        wait_gnt();
        checks++;
        if (bus.gnt !== 4'b0100) begin
            failures++;
            $display("FAIL data_gnt got=%b exp=0100", bus.gnt);
        end
        step();
        checks++;
        if (bus.tx_start !== 1'b1 || bus.tx_data !== 8'hA5) begin
            failures++;
            $display("FAIL data_start got start=%b data=%h exp start=1 data=a5", bus.tx_start, bus.tx_data);
        end
        bus.req = '0;
        bus.req_data = '0;
        bus.tx_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (bus.tx_data !== 8'hA5 || owner !== 2'd2) begin
                failures++;
                $display("FAIL data_hold%0d got data=%h owner=%0d exp data=a5 owner=2", i, bus.tx_data, owner);
            end
        end
        pulse_done();
        checks++;
        if (bus.done !== 4'b0100 || bus.tx_data !== 8'hA5 || owner !== 2'd2) begin
            failures++;
            $display("FAIL data_done got done=%b data=%h owner=%0d exp done=0100 data=a5 owner=2",
                     bus.done, bus.tx_data, owner);
        end
        step();
    endtask

    task automatic test_blocking();
        bus.tx_busy = 1'b1;
        bus.req = 4'b0100;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (bus.gnt !== 4'b0000 || busy !== 1'b0) begin
                failures++;
                $display("FAIL block%0d got gnt=%b busy=%b exp gnt=0000 busy=0", i, bus.gnt, busy);
            end
        end
        bus.tx_busy = 1'b0;
        step();
        checks++;
        if (bus.gnt !== 4'b0100) begin
            failures++;
            $display("FAIL block_release got=%b exp=0100", bus.gnt);
        end
        bus.req = '0;
        wait_start();
        pulse_done();
        step();
    endtask

    task automatic test_edge_cases();
        bus.tx_done = 1'b1;
        step();
        bus.tx_done = 1'b0;
        step();
        checks++;
        if (bus.done !== 4'b0000 || busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_txdone got done=%b busy=%b exp done=0000 busy=0", bus.done, busy);
        end
        bus.req = 4'b0001;
        wait_gnt();
        checks++;
        if (bus.gnt !== 4'b0001) begin
            failures++;
            $display("FAIL edge_gnt got=%b exp=0001", bus.gnt);
        end
        bus.tx_done = 1'b1;
        bus.req = 4'b0010;
        step();
        bus.tx_done = 1'b0;
        bus.req = '0;
        checks++;
        if (busy !== 1'b1 || bus.done !== 4'b0000 || bus.tx_start !== 1'b1) begin
            failures++;
            $display("FAIL start_txdone got busy=%b done=%b start=%b exp busy=1 done=0000 start=1",
                     busy, bus.done, bus.tx_start);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (busy !== 1'b1 || bus.done !== 4'b0000 || bus.gnt !== 4'b0000) begin
                failures++;
                $display("FAIL edge_wait%0d got busy=%b done=%b gnt=%b exp busy=1 done=0000 gnt=0000",
                         i, busy, bus.done, bus.gnt);
            end
        end
        pulse_done();
        checks++;
        if (bus.done !== 4'b0001) begin
            failures++;
            $display("FAIL edge_done got=%b exp=0001", bus.done);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (bus.gnt !== 4'b0000) begin
                failures++;
                $display("FAIL short_req%0d got=%b exp=0000", i, bus.gnt);
            end
        end
    endtask

    task automatic test_single_wrap();
        bus.req = 4'b1000;
        wait_gnt();
        checks++;
        if (bus.gnt !== 4'b1000) begin
            failures++;
            $display("FAIL single_gnt0 got=%b exp=1000", bus.gnt);
        end
        wait_start();
        pulse_done();
        checks++;
        if (bus.done !== 4'b1000) begin
            failures++;
            $display("FAIL single_done got=%b exp=1000", bus.done);
        end
        wait_gnt();
        checks++;
        if (bus.gnt !== 4'b1000) begin
            failures++;
            $display("FAIL single_gnt1 got=%b exp=1000", bus.gnt);
        end
        bus.req = '0;
        wait_start();
        pulse_done();
        step();
        bus.req = 4'b0001;
        wait_gnt();
        checks++;
        if (bus.gnt !== 4'b0001 || owner !== 2'd0) begin
            failures++;
            $display("FAIL wrap_gnt got gnt=%b owner=%0d exp gnt=0001 owner=0", bus.gnt, owner);
        end
        bus.req = '0;
        wait_start();
        pulse_done();
        step();
    endtask

    task automatic test_watchdog();
        bus.req = 4'b0001;
        wait_gnt();
        bus.req = '0;
        step();
        checks++;
        if (bus.tx_start !== 1'b1) begin
            failures++;
            $display("FAIL wd_start got=%b exp=1", bus.tx_start);
        end
`ifdef UART_ARB_TIMEOUT_EN
        repeat (15) step();
        checks++;
        if (timeout_err !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL wd_before got terr=%b busy=%b exp terr=0 busy=1", timeout_err, busy);
        end
        step();
        checks++;
        if (timeout_err !== 1'b1 || busy !== 1'b0 || bus.done !== 4'b0000) begin
            failures++;
            $display("FAIL wd_fire got terr=%b busy=%b done=%b exp terr=1 busy=0 done=0000",
                     timeout_err, busy, bus.done);
        end
        step();
        checks++;
        if (timeout_err !== 1'b0) begin
            failures++;
            $display("FAIL wd_pulse got=%b exp=0", timeout_err);
        end
`else
        begin
            logic seen = 1'b0;
            repeat (40) begin
                step();
                seen = seen | timeout_err | ~busy;
            end
            checks++;
            if (seen !== 1'b0) begin
                failures++;
                $display("FAIL wd_disabled got terr_or_idle=%b exp=0", seen);
            end
        end
        pulse_done();
        checks++;
        if (bus.done !== 4'b0001 || timeout_err !== 1'b0) begin
            failures++;
            $display("FAIL wd_done got done=%b terr=%b exp done=0001 terr=0", bus.done, timeout_err);
        end
        step();
`endif
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_data();
        test_blocking();
        test_edge_cases();
        test_single_wrap();
        test_watchdog();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
